// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the pc_fetch stage
package fetch_pkg;

  // Control FSM states of the fetch stage
  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_e;

  // Reason recorded when the stage enters HALT
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10,
    CAUSE_HALT     = 2'b11
  } trap_cause_e;

  // addi x0, x0, 0 - presented to decode whenever no real fetch is valid
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction memory bus between fetch and imem
interface pc_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  // Fetch stage drives the address and consumes the combinational read data
  modport master (output imem_addr, input imem_rdata);
  // Instruction memory side
  modport slave (input imem_addr, output imem_rdata);
endinterface

// File: rtl/pc_target_check.sv
// rtl/pc_target_check.sv - alignment and range check of a candidate PC
module pc_target_check #(
  parameter int IMEM_DEPTH = 64
) (
  input  logic [31:0] target,
  output logic        misaligned,
  output logic        out_of_range
);

  // First illegal byte address; 33 bits so the compare cannot overflow
  localparam logic [32:0] LIMIT = {1'b0, 32'(IMEM_DEPTH)} << 2;

  // Word alignment and upper bound of the instruction memory
  always_comb begin
    misaligned   = |target[1:0];
    out_of_range = ({1'b0, target} >= LIMIT);
  end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - fetch stage: PC, next-PC select, boot/run/halt FSM (optional FETCH_PERF_CNT_EN)
module pc_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  input  logic              halt_req,
  pc_fetch_if.master        imem,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              halted,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [31:0]       trap_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         trap_q, trap_d;
  trap_cause_e  cause_q, cause_d;
  logic [31:0]  trap_pc_q, trap_pc_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  count_q, count_d;
`endif

  logic [31:0]  seq_pc;
  logic [31:0]  next_pc;
  logic         tgt_misaligned;
  logic         tgt_out_of_range;

  // Candidate next PC: jump beats branch beats sequential; JALR bit 0 cleared
  always_comb begin
    seq_pc = pc_q + 32'd4;
    if (jump) begin
      next_pc = {jump_target[31:1], 1'b0};
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else begin
      next_pc = seq_pc;
    end
  end

  pc_target_check #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_check (
    .target       (next_pc),
    .misaligned   (tgt_misaligned),
    .out_of_range (tgt_out_of_range)
  );

  // Next-state and register updates; halt_req outranks stall, stall freezes everything
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_d    = 1'b0;
    cause_d   = cause_q;
    trap_pc_d = trap_pc_q;
`ifdef FETCH_PERF_CNT_EN
    count_d   = count_q;
`endif
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req) begin
          state_d   = ST_HALT;
          cause_d   = CAUSE_HALT;
          trap_pc_d = pc_q;
        end else if (!stall) begin
          if (tgt_misaligned || tgt_out_of_range) begin
            state_d   = ST_HALT;
            trap_d    = 1'b1;
            cause_d   = tgt_misaligned ? CAUSE_MISALIGN : CAUSE_RANGE;
            trap_pc_d = pc_q;
          end else begin
            pc_d = next_pc;
`ifdef FETCH_PERF_CNT_EN
            count_d = count_q + 32'd1;
`endif
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  // State and architectural registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      trap_pc_q <= 32'h0;
`ifdef FETCH_PERF_CNT_EN
      count_q   <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      trap_pc_q <= trap_pc_d;
`ifdef FETCH_PERF_CNT_EN
      count_q   <= count_d;
`endif
    end
  end

  // Zero-latency fetch outputs derived from the current PC and state
  always_comb begin
    imem.imem_addr = pc_q;
    pc             = pc_q;
    pc_plus4       = seq_pc;
    instr_valid    = (state_q == ST_RUN);
    instr          = instr_valid ? imem.imem_rdata : NOP_INSTR;
    halted         = (state_q == ST_HALT);
    trap           = trap_q;
    trap_cause     = cause_q;
    trap_pc        = trap_pc_q;
`ifdef FETCH_PERF_CNT_EN
    fetch_count    = count_q;
`endif
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed scoreboard bench for pc_fetch
module tb_pc_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        halt_req = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] trap_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  pc_fetch_if imem ();

  pc_fetch #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt_req      (halt_req),
    .imem          (imem),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .halted        (halted),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_model(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[23:0], 8'h13};
  endfunction

  always_comb imem.imem_rdata = imem_model(imem.imem_addr);

  task automatic exp(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic got(input logic [31:0] obs);
    sb_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: observed %h, required a queued expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
    end
  endtask

  task automatic check_all(input logic [31:0] e_pc, input logic e_valid, input logic e_halted,
                           input logic e_trap, input logic [1:0] e_cause, input logic [31:0] e_tpc);
    exp("pc", e_pc);
    exp("pc_plus4", e_pc + 32'd4);
    exp("imem_addr", e_pc);
    exp("instr_valid", {31'b0, e_valid});
    exp("instr", e_valid ? imem_model(e_pc) : NOP_INSTR);
    exp("halted", {31'b0, e_halted});
    exp("trap", {31'b0, e_trap});
    exp("trap_cause", {30'b0, e_cause});
    exp("trap_pc", e_tpc);
    got(pc);
    got(pc_plus4);
    got(imem.imem_addr);
    got({31'b0, instr_valid});
    got(instr);
    got({31'b0, halted});
    got({31'b0, trap});
    got({30'b0, trap_cause});
    got(trap_pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state while rst_n is low
    #3;
    check_all(32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // BOOT cycle, then first RUN fetch, then sequential advance
    check_all(32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    tick();
    check_all(32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    tick();
    check_all(32'h4, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    tick();
    check_all(32'h8, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    // jump wins over branch, bit 0 cleared
    branch_taken = 1'b1; branch_target = 32'h20; jump = 1'b1; jump_target = 32'h41;
    tick();
    branch_taken = 1'b0; jump = 1'b0;
    check_all(32'h40, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    // stall holds and discards the branch
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all(32'h40, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    end
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    check_all(32'h44, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    // plain branch
    branch_taken = 1'b1; branch_target = 32'h10;
    tick();
    branch_taken = 1'b0;
    check_all(32'h10, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    // misaligned jump traps
    jump = 1'b1; jump_target = 32'h102;
    tick();
    check_all(32'h10, 1'b0, 1'b1, 1'b1, 2'b01, 32'h10);
    // HALT ignores inputs; trap is a single pulse
    halt_req = 1'b1;
    tick();
    jump = 1'b0; halt_req = 1'b0;
    check_all(32'h10, 1'b0, 1'b1, 1'b0, 2'b01, 32'h10);
    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_all(32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    // sequential run to the end of imem
    for (int i = 0; i < 63; i++) tick();
    check_all(32'hFC, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    exp("fetch_count", 32'd63);
    got(fetch_count);
`endif
    tick();
    check_all(32'hFC, 1'b0, 1'b1, 1'b1, 2'b10, 32'hFC);
`ifdef FETCH_PERF_CNT_EN
    exp("fetch_count_hold", 32'd63);
    got(fetch_count);
`endif
    // misaligned and out-of-range together report misaligned
    rst_n = 1'b0;
    #1;
    check_all(32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    branch_taken = 1'b1; branch_target = 32'h203;
    tick();
    branch_taken = 1'b0;
    check_all(32'h0, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0);
    // halt_req at 0x0C, then reset mid-HALT
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check_all(32'hC, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_all(32'hC, 1'b0, 1'b1, 1'b0, 2'b11, 32'hC);
    tick();
    check_all(32'hC, 1'b0, 1'b1, 1'b0, 2'b11, 32'hC);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    exp("fetch_count_reset", 32'd0);
    got(fetch_count);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
